shift_add_multiplier: RTL

Sequential 8-bit signed (two's-complement) add-shift multiplier core for the Lab 5 multiplier top level. It consumes the raw push-button and slider-switch inputs (Run, ClearA_LoadB, S) and produces the A/B/X register contents. The top level registers these contents into Aval, Bval and X, and drives the hex displays from them. The 16-bit product is {Aval, Bval}; X is its sign.

---
 rtl/shift_add_multiplier.sv | 138 +++++++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential 8x8 signed add-shift multiplier core.
// Button inputs are synchronised, then a small FSM performs eight ADD/SHIFT
// iterations on {X,A,B}; the last add becomes a subtract to account for the
// negative weight of the multiplier sign bit. The product ends up in {A,B}.
module shift_add_multiplier (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ClearA_LoadB,
    input  logic       Run,
    input  logic [7:0] S,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       X,
    output logic       Done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_run_meta;
    logic        r_run_s;
    logic        r_clr_meta;
    logic        r_clr_s;
    logic        r_x;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_m;
    logic [2:0]  r_cnt;
    logic        r_done;

    logic signed [8:0] w_a_ext;
    logic signed [8:0] w_m_ext;
    logic signed [8:0] w_sum;
    logic signed [8:0] w_diff;

    // Sign-extend A and M to 9 bits so the add/subtract produces the new X as its MSB.
    assign w_a_ext = $signed({r_a[7], r_a});
    assign w_m_ext = $signed({r_m[7], r_m});
    assign w_sum   = w_a_ext + w_m_ext;
    assign w_diff  = w_a_ext - w_m_ext;

    assign Aval = r_a;
    assign Bval = r_b;
    assign X    = r_x;
    assign Done = r_done;

    // Two-flop synchronizers for the active-low buttons; idle level is released (1).
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_run_meta <= 1'b1;
            r_run_s    <= 1'b1;
            r_clr_meta <= 1'b1;
            r_clr_s    <= 1'b1;
        end else begin
            r_run_meta <= Run;
            r_run_s    <= r_run_meta;
            r_clr_meta <= ClearA_LoadB;
            r_clr_s    <= r_clr_meta;
        end
    end

    // Control FSM and datapath registers: load, clear, eight add/shift rounds, hold.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_x     <= 1'b0;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_m     <= 8'h00;
            r_cnt   <= 3'd0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    // Load has priority; a held Run starts once the load button is released.
                    if (!r_clr_s) begin
                        r_a <= 8'h00;
                        r_x <= 1'b0;
                        r_b <= S;
                    end else if (!r_run_s) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_a     <= 8'h00;
                    r_x     <= 1'b0;
                    r_m     <= S;
                    r_cnt   <= 3'd0;
                    r_state <= ST_ADD;
                end
                ST_ADD: begin
                    if (r_b[0]) begin
                        // Final round weights the multiplier sign bit by -2^7.
                        if (r_cnt == 3'd7) begin
                            r_x <= w_diff[8];
                            r_a <= w_diff[7:0];
                        end else begin
                            r_x <= w_sum[8];
                            r_a <= w_sum[7:0];
                        end
                    end
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Arithmetic right shift of {X,A,B}; X replicates into A.
                    r_a <= {r_x, r_a[7:1]};
                    r_b <= {r_a[0], r_b[7:1]};
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_HOLD;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_state <= ST_ADD;
                    end
                end
                ST_HOLD: begin
                    // Wait for Run release so one press yields exactly one product.
                    if (r_run_s) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
